wb_result_buffer: RTL and testbench

Per-unit result FIFO between a multi-cycle execution unit's result stage and the writeback mux. It captures completed results (id, rd) from the unit pipeline and presents them on the unit writeback handshake (done/id/rd/ack). It holds each result until the writeback stage acknowledges it, so the unit never stalls its pipeline on writeback arbitration until the buffer fills.

---
 rtl/wb_result_buffer.sv | 130 +++++++++++++
 tb/tb_wb_result_buffer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : wb_result_buffer
// Description : Per-unit result FIFO between a multi-cycle execution unit's
//               result stage and the writeback mux. Completed results
//               (id, rd) are captured from the unit pipeline and held on the
//               writeback handshake (done/id/rd/ack) until acknowledged.
//
// Parameters  : DEPTH      - number of result entries (power of two, >= 2)
//               DATA_WIDTH - result data width
//               ID_WIDTH   - instruction id width
//
// Ports       : clk, rst    - clock, synchronous active-high reset
//               in_valid    - unit pushes a result this cycle
//               in_id/in_rd - id and data of the pushed result
//               in_ready    - buffer can accept a push (registered count only)
//               wb_done     - head result valid
//               wb_id/wb_rd - head id and data
//               wb_ack      - writeback consumed the head this cycle
//               occupancy   - number of stored entries
//               overflow    - sticky: push attempted while not ready
//
// Build macro : CVA5_WB_RESULT_BYPASS_EN - when defined, an empty buffer
//               forwards an incoming result straight to the wb_* outputs in
//               the same cycle; if it is acknowledged in that cycle it is
//               never stored.
//
// Revision    : 1.0 - initial release
// ============================================================================
module wb_result_buffer #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [ID_WIDTH-1:0]      in_id,
    input  logic [DATA_WIDTH-1:0]    in_rd,
    output logic                     in_ready,
    output logic                     wb_done,
    output logic [ID_WIDTH-1:0]      wb_id,
    output logic [DATA_WIDTH-1:0]    wb_rd,
    input  logic                     wb_ack,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     overflow
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PINC = c_PTR_W'(1);

    logic [ID_WIDTH-1:0]   r_mem_id [DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_rd [DEPTH];
    logic [c_PTR_W-1:0]    r_rptr;
    logic [c_PTR_W-1:0]    r_wptr;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_overflow;

    logic w_not_empty;
    logic w_push;
    logic w_store;
    logic w_pop;

    assign w_not_empty = (r_count != '0);

    // Readiness depends only on the registered count: a full buffer refuses
    // a push even if the head is popped in the same cycle.
    assign in_ready = (r_count != c_FULL);
    assign w_push   = in_valid & in_ready;

    // Storage pops only when a stored entry is acknowledged; a bypassed
    // result never touches the pointers.
    assign w_pop = w_not_empty & wb_ack;

`ifdef CVA5_WB_RESULT_BYPASS_EN
    logic w_bypass;

    assign w_bypass = ~w_not_empty & in_valid;
    assign w_store  = w_push & ~(w_bypass & wb_ack);
    assign wb_done  = w_not_empty | w_bypass;
    assign wb_id    = w_bypass ? in_id : r_mem_id[r_rptr];
    assign wb_rd    = w_bypass ? in_rd : r_mem_rd[r_rptr];
`else
    assign w_store  = w_push;
    assign wb_done  = w_not_empty;
    assign wb_id    = r_mem_id[r_rptr];
    assign wb_rd    = r_mem_rd[r_rptr];
`endif

    assign occupancy = r_count;
    assign overflow  = r_overflow;

    // Data storage carries no reset; contents are only observed while the
    // count says they are valid.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem_id[r_wptr] <= in_id;
            r_mem_rd[r_wptr] <= in_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_store) begin
                r_wptr <= r_wptr + c_PINC;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PINC;
            end
            if (w_store && !w_pop) begin
                r_count <= r_count + c_ONE;
            end else if (!w_store && w_pop) begin
                r_count <= r_count - c_ONE;
            end
            if (in_valid && !in_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_result_buffer
// Description : Self-checking bench for wb_result_buffer. A queue-based
//               reference model tracks the expected FIFO contents, handshake
//               outputs and sticky overflow; directed and randomized
//               stimulus is applied one cycle at a time.
//               Honours CVA5_WB_RESULT_BYPASS_EN for its expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_result_buffer;

    localparam int DEPTH      = 4;
    localparam int DATA_WIDTH = 32;
    localparam int ID_WIDTH   = 3;
    localparam int c_OCC_W    = $clog2(DEPTH) + 1;

`ifdef CVA5_WB_RESULT_BYPASS_EN
    localparam bit c_BYPASS = 1'b1;
`else
    localparam bit c_BYPASS = 1'b0;
`endif

    logic                  clk;
    logic                  rst;
    logic                  in_valid;
    logic [ID_WIDTH-1:0]   in_id;
    logic [DATA_WIDTH-1:0] in_rd;
    logic                  in_ready;
    logic                  wb_done;
    logic [ID_WIDTH-1:0]   wb_id;
    logic [DATA_WIDTH-1:0] wb_rd;
    logic                  wb_ack;
    logic [c_OCC_W-1:0]    occupancy;
    logic                  overflow;

    wb_result_buffer #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ID_WIDTH   (ID_WIDTH)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_id     (in_id),
        .in_rd     (in_rd),
        .in_ready  (in_ready),
        .wb_done   (wb_done),
        .wb_id     (wb_id),
        .wb_rd     (wb_rd),
        .wb_ack    (wb_ack),
        .occupancy (occupancy),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: entries are {id, rd}, oldest at index 0.
    logic [ID_WIDTH+DATA_WIDTH-1:0] m_q[$];
    bit                             m_ovf;
    int                             n_accepted;
    logic [ID_WIDTH-1:0]            popped_ids[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model before
    // the edge, advance the model, then step past the edge.
    task automatic cycle(input bit v, input logic [ID_WIDTH-1:0] id,
                         input logic [DATA_WIDTH-1:0] rd, input bit ack);
        bit exp_ready, bypass, exp_done, pop;
        logic [ID_WIDTH+DATA_WIDTH-1:0] head;
        in_valid = v;
        in_id    = id;
        in_rd    = rd;
        wb_ack   = ack;
        #1;
        exp_ready = (m_q.size() < DEPTH);
        bypass    = c_BYPASS && (m_q.size() == 0) && v;
        exp_done  = (m_q.size() > 0) || bypass;
        head      = bypass ? {id, rd} : ((m_q.size() > 0) ? m_q[0] : '0);
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        chk("wb_done", 64'(wb_done), 64'(exp_done));
        chk("occupancy", 64'(occupancy), 64'(m_q.size()));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        if (exp_done) begin
            chk("wb_id", 64'(wb_id), 64'(head[ID_WIDTH+DATA_WIDTH-1:DATA_WIDTH]));
            chk("wb_rd", 64'(wb_rd), 64'(head[DATA_WIDTH-1:0]));
        end
        pop = exp_done && ack;
        if (pop) popped_ids.push_back(head[ID_WIDTH+DATA_WIDTH-1:DATA_WIDTH]);
        if (v && !exp_ready) m_ovf = 1'b1;
        if (pop && !bypass) void'(m_q.pop_front());
        if (v && exp_ready) begin
            n_accepted++;
            if (!(bypass && ack)) m_q.push_back({id, rd});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_id    = '0;
        in_rd    = '0;
        wb_ack   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_q.delete();
        m_ovf = 1'b0;
        popped_ids.delete();
    endtask

    task automatic idle();
        cycle(1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        int cyc;
        bit v, a;
        do_reset();

        // Reset state
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_wb_done", 64'(wb_done), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);

        // Single push, visible on the next cycle
        cycle(1'b1, 3'd1, 32'hA5A5_0001, 1'b0);
        chk("single_done", 64'(wb_done), 64'd1);
        chk("single_id", 64'(wb_id), 64'd1);
        chk("single_rd", 64'(wb_rd), 64'hA5A5_0001);
        chk("single_occ", 64'(occupancy), 64'd1);

        // Fill, then push-with-pop while full
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, ID_WIDTH'(i), 32'h1000 + i, 1'b0);
        chk("full_ready", 64'(in_ready), 64'd0);
        chk("full_occ", 64'(occupancy), 64'(DEPTH));
        cycle(1'b1, 3'd7, 32'hDEAD, 1'b1);
        chk("full_ovf", 64'(overflow), 64'd1);
        chk("full_occ_after", 64'(occupancy), 64'(DEPTH - 1));
        chk("full_ready_after", 64'(in_ready), 64'd1);
        for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, '0, '0, 1'b1);
        for (int i = 0; i < DEPTH; i++) chk("full_drain_order", 64'(popped_ids[i]), 64'(i));
        idle();
        chk("full_ovf_sticky", 64'(overflow), 64'd1);

        // Continuous push with ack tied high, across pointer wrap
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, ID_WIDTH'(i), 32'hC0DE_0000 + i, 1'b1);
            chk("stream_occ", 64'(occupancy), c_BYPASS ? 64'd0 : 64'd1);
        end
        cycle(1'b0, '0, '0, 1'b1);
        chk("stream_count", 64'(popped_ids.size()), 64'd16);
        for (int i = 0; i < 16; i++) chk("stream_order", 64'(popped_ids[i]), 64'(i % 8));
        chk("stream_ovf", 64'(overflow), 64'd0);

        // Random traffic, pushes gated by the model's view of in_ready
        do_reset();
        n_accepted = 0;
        cyc = 0;
        while (n_accepted < 1000 && cyc < 20000) begin
            v = ($urandom_range(0, 3) != 0) && (m_q.size() < DEPTH);
            a = ($urandom_range(0, 2) != 0);
            cycle(v, ID_WIDTH'($urandom), $urandom, a);
            cyc++;
        end
        chk("rand_accepted", 64'(n_accepted), 64'd1000);
        cyc = 0;
        while (m_q.size() > 0 && cyc < 100) begin
            cycle(1'b0, '0, '0, 1'b1);
            cyc++;
        end
        chk("rand_drained", 64'(occupancy), 64'd0);
        chk("rand_popped", 64'(popped_ids.size()), 64'd1000);
        chk("rand_ovf", 64'(overflow), 64'd0);

        // Reset mid-operation
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, ID_WIDTH'(i + 2), 32'h55 + i, 1'b0);
        cycle(1'b1, 3'd6, 32'h66, 1'b0);
        cycle(1'b1, 3'd7, 32'h77, 1'b0);
        chk("pre_rst_ovf", 64'(overflow), 64'd1);
        do_reset();
        chk("mid_rst_done", 64'(wb_done), 64'd0);
        chk("mid_rst_occ", 64'(occupancy), 64'd0);
        chk("mid_rst_ovf", 64'(overflow), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);

        // Empty buffer, push with simultaneous ack
        do_reset();
        in_valid = 1'b1;
        in_id    = 3'd5;
        in_rd    = 32'h1234;
        wb_ack   = 1'b1;
        #1;
        chk("byp_done", 64'(wb_done), c_BYPASS ? 64'd1 : 64'd0);
        if (c_BYPASS) chk("byp_id", 64'(wb_id), 64'd5);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wb_ack   = 1'b0;
        #1;
        chk("byp_occ", 64'(occupancy), c_BYPASS ? 64'd0 : 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
